// File: rtl/ledsweeper.sv
// Cylon-style LED sweeper: a carry-out accumulator sets the step rate, and a one-hot owner walks the LEDs.
// Each LED's brightness decays by halving on every step, so the owner leaves a fading PWM trail.
module ledsweeper #(
    parameter int NLEDS   = 8,
    parameter int CTRBITS = 25,
    parameter int PWMBITS = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_en,
    input  logic [CTRBITS-1:0]       i_step,
    input  logic [1:0]               i_mode,
    output logic [NLEDS-1:0]         o_leds,
    output logic [$clog2(NLEDS)-1:0] o_pos,
    output logic                     o_tick
);

    localparam int POSBITS = $clog2(NLEDS);
    localparam logic [NLEDS-1:0] OWNER_LSB = NLEDS'(1);

    typedef enum logic [1:0] {
        MODE_BOUNCE    = 2'd0,
        MODE_WRAP_UP   = 2'd1,
        MODE_WRAP_DOWN = 2'd2,
        MODE_FREEZE    = 2'd3
    } mode_t;

    mode_t              mode;
    logic [CTRBITS-1:0] ctr;
    logic [CTRBITS:0]   sum;
    logic               tick;
    logic [NLEDS-1:0]   owner;
    logic [NLEDS-1:0]   owner_next;
    logic               dir;
    logic               dir_next;
    logic               owner_ok;
    logic [POSBITS-1:0] owner_idx;
    logic [PWMBITS-1:0] br;
    logic [PWMBITS-1:0] pwm [NLEDS];

    assign mode = mode_t'(i_mode);
    assign sum  = {1'b0, ctr} + {1'b0, i_step};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ctr  <= '0;
            tick <= 1'b0;
        end else if (i_en) begin
            {tick, ctr} <= sum;
        end else begin
            tick <= 1'b0;
        end
    end

    assign owner_ok = (owner != '0) && ((owner & (owner - OWNER_LSB)) == '0);

    // A corrupted owner is repaired on the very next clock, ahead of any mode or tick logic.
    always_comb begin
        owner_next = owner;
        dir_next   = dir;
        if (!owner_ok) begin
            owner_next = OWNER_LSB;
            dir_next   = 1'b1;
        end else if (tick) begin
            case (mode)
                MODE_BOUNCE: begin
                    if (dir) begin
                        if (owner[NLEDS-1]) dir_next = 1'b0;
                        else                owner_next = owner << 1;
                    end else begin
                        if (owner[0]) dir_next = 1'b1;
                        else          owner_next = owner >> 1;
                    end
                end
                MODE_WRAP_UP: begin
                    owner_next = {owner[NLEDS-2:0], owner[NLEDS-1]};
                    dir_next   = 1'b1;
                end
                MODE_WRAP_DOWN: begin
                    owner_next = {owner[0], owner[NLEDS-1:1]};
                    dir_next   = 1'b0;
                end
                default: begin
                    owner_next = owner;
                    dir_next   = dir;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            owner <= OWNER_LSB;
            dir   <= 1'b1;
        end else begin
            owner <= owner_next;
            dir   <= dir_next;
        end
    end

    // The newly chosen owner is lit at full brightness on the same tick it takes over.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NLEDS; k++) pwm[k] <= '0;
        end else if (tick) begin
            for (int k = 0; k < NLEDS; k++) begin
                pwm[k] <= owner_next[k] ? {PWMBITS{1'b1}} : (pwm[k] >> 1);
            end
        end
    end

    always_comb begin
        owner_idx = '0;
        for (int k = NLEDS - 1; k >= 0; k--) begin
            if (owner[k]) owner_idx = POSBITS'(k);
        end
    end

    // Bit-reversing the low counter bits spreads the PWM on-time instead of lumping it together.
    always_comb begin
        br = '0;
        for (int k = 0; k < PWMBITS; k++) br[k] = ctr[PWMBITS-1-k];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_leds <= '0;
            o_pos  <= '0;
            o_tick <= 1'b0;
        end else begin
            o_tick <= tick;
            o_pos  <= owner_idx;
            for (int k = 0; k < NLEDS; k++) begin
                if (&pwm[k])            o_leds[k] <= 1'b1;
                else if (pwm[k] == '0)  o_leds[k] <= 1'b0;
                else                    o_leds[k] <= (br <= pwm[k]);
            end
        end
    end

endmodule
